aes_mix_columns_iter: RTL and testbench
=======================================

# aes_mix_columns_iter

Iterative MixColumns / InvMixColumns engine for the AES cipher core. It accepts a full 128-bit state over a valid/ready handshake and transforms one 32-bit column per cycle, using the existing single-column mixer. The result is presented on a second valid/ready handshake. Its main use is the decryption side of the key path: it converts stored encryption round keys into equivalent-inverse-cipher round keys without instantiating four mixers.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous flush; wins over every other input
- in_valid_i  in  1  input block valid
- in_ready_o  out  1  engine can accept a block
- mode_i  in  1  AES_ENC (1'b0) selects MixColumns; AES_DEC (1'b1) selects InvMixColumns; sampled on input handshake
- data_i  in  128  input state
  - column c at bits [127-32c -: 32]
  - within a column, row 0 at [31:24] and row 3 at [7:0]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- data_o  out  128  result, same byte order as data_i; forced to 0 whenever out_valid_o=0
- busy_o  out  1  high when the FSM is not in IDLE

## Operation
- The state register holds 128 bits. A 2-bit column counter col_q selects the column routed through the mixer.
- mode_q is latched at the input handshake. mode_i changes after acceptance have no effect.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && !clear_i: load state ← data_i, mode_q ← mode_i, col_q ← 0, go to BUSY.
- BUSY:
  - Each cycle, column col_q of the state is replaced with mix(col_q, mode_q). The other three columns hold.
  - col_q increments each cycle.
  - When col_q==3 the update still occurs, col_q wraps to 0, and the FSM goes to DONE.
- DONE:
  - out_valid_o=1 and data_o=state.
  - On out_ready_i: go to IDLE and zero the state register.
  - No new block is accepted in the same cycle, because in_ready_o=0 in DONE.
- clear_i (any state, sampled at the edge):
  - FSM → IDLE; state, col_q and mode_q → 0.
  - An input offered on the same edge is ignored.
- Arithmetic: GF(2^8) with polynomial x^8+x^4+x^3+x+1. This is bit-exact with the existing single-column mixer.

## Timing
- Reset values:
  - in_ready_o=1
  - out_valid_o=0
  - busy_o=0
  - data_o=0
  - internal state, col_q, mode_q all 0
- Latency: input handshake at edge T; columns 0..3 are written at edges T+1..T+4; out_valid_o rises after edge T+4.
- Throughput: a new block is accepted earliest one cycle after the output handshake. The minimum period is 6 cycles per block with out_ready_i tied high.
- Output stall: while out_ready_i=0, out_valid_o and data_o hold stable indefinitely.
- Valid behaviour: in_valid_i may drop without being accepted, and there is no requirement that it stay asserted. out_valid_o never drops without a handshake, except on clear_i or reset.
- Reset asserted mid-BUSY or mid-DONE: all outputs return to their reset values immediately (asynchronously). No partial result is ever emitted.
- in_ready_o, out_valid_o and busy_o are decoded from registered state only. They have no combinational dependence on any input.

## Structure
- The shared aes_pkg provides:
  - the AES_ENC/AES_DEC mode constants
  - the mul2 helper function
  - a new enum aes_mixc_iter_e {IDLE, BUSY, DONE}
- Exactly one sub-module: aes_mix_single_column.
  - Its mode_i is driven by mode_q.
  - Its data_i is driven by the column selected by col_q.
- Column select and write-back are implemented as a 4:1 mux plus per-column write enables. Both are local logic.

## Test plan
- MixColumns: mode_i=AES_ENC, data_i=db135345_f20a225c_01010101_2d26314c, out_ready_i=1.
  - Required result: out_valid_o exactly 4 cycles after acceptance, data_o=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
- InvMixColumns: mode_i=AES_DEC with the previous result as input.
  - Required result: data_o=db135345_f20a225c_01010101_2d26314c, and data_o=0 in every cycle with out_valid_o=0.
- Backpressure: hold out_ready_i=0 for 10 cycles after DONE.
  - Required result: out_valid_o=1 and data_o stable throughout, in_ready_o=0.
  - After the handshake: in_ready_o=1 one cycle later.
- Mode stability: toggle mode_i every cycle during BUSY on the c6c6c6c6_d4d4d4d5_… block in ENC mode.
  - Required result: d4d4d4d5 → d5d5d7d6, unaffected by the toggling.
- clear_i asserted in the 2nd BUSY cycle, with in_valid_i high on the same edge.
  - Required result: next cycle IDLE, busy_o=0, out_valid_o never asserts.
  - A subsequent block completes normally.
- Async reset pulse mid-BUSY and mid-DONE.
  - Required result: immediate return of all outputs to reset values.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: cipher direction constants, GF(2^8) doubling helper
// and the state encoding of the iterative MixColumns engine.
package aes_pkg;

   localparam logic AES_ENC = 1'b0;
   localparam logic AES_DEC = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } aes_mixc_iter_e;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Single-column MixColumns / InvMixColumns. The inverse reuses the forward
// network after a cheap pre-multiplication by {05,00,04,00} circulant.
module aes_mix_single_column
   import aes_pkg::*;
(
   input  logic        mode_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] u, v;
   logic [7:0] p0, p1, p2, p3;
   logic       dec;

   assign a0  = data_i[31:24];
   assign a1  = data_i[23:16];
   assign a2  = data_i[15:8];
   assign a3  = data_i[7:0];
   assign dec = (mode_i == AES_DEC);

   assign u = mul2(mul2(a0 ^ a2));
   assign v = mul2(mul2(a1 ^ a3));

   assign p0 = dec ? (a0 ^ u) : a0;
   assign p1 = dec ? (a1 ^ v) : a1;
   assign p2 = dec ? (a2 ^ u) : a2;
   assign p3 = dec ? (a3 ^ v) : a3;

   assign data_o[31:24] = mul2(p0) ^ mul2(p1) ^ p1 ^ p2 ^ p3;
   assign data_o[23:16] = p0 ^ mul2(p1) ^ mul2(p2) ^ p2 ^ p3;
   assign data_o[15:8]  = p0 ^ p1 ^ mul2(p2) ^ mul2(p3) ^ p3;
   assign data_o[7:0]   = mul2(p0) ^ p0 ^ p1 ^ p2 ^ mul2(p3);

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns engine: one column per cycle through a shared mixer.
//   state | meaning
//   IDLE  | ready for a new 128-bit block
//   BUSY  | mixing column col_q, four cycles total
//   DONE  | result presented, waiting for out_ready_i
module aes_mix_columns_iter
   import aes_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic         mode_i,
   input  logic [127:0] data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] data_o,
   output logic         busy_o
);

   aes_mixc_iter_e state_q, state_d;
   logic [127:0]   data_q;
   logic [1:0]     col_q;
   logic           mode_q;
   logic [31:0]    col_sel;
   logic [31:0]    col_mixed;
   logic [3:0]     col_we;
   logic           load, step, unload;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      unload  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               state_d = BUSY;
               load    = 1'b1;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (col_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
               unload  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      col_sel = 32'h0;
      case (col_q)
         2'd0: col_sel = data_q[127:96];
         2'd1: col_sel = data_q[95:64];
         2'd2: col_sel = data_q[63:32];
         2'd3: col_sel = data_q[31:0];
         default: col_sel = 32'h0;
      endcase
   end

   assign col_we = step ? (4'b0001 << col_q) : 4'b0000;

   aes_mix_single_column u_mix (
      .mode_i (mode_q),
      .data_i (col_sel),
      .data_o (col_mixed)
   );

   // clear_i outranks the handshakes so a flushed block never lands.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         col_q  <= 2'd0;
         mode_q <= AES_ENC;
      end else if (clear_i) begin
         data_q <= '0;
         col_q  <= 2'd0;
         mode_q <= AES_ENC;
      end else if (load) begin
         data_q <= data_i;
         mode_q <= mode_i;
         col_q  <= 2'd0;
      end else if (step) begin
         for (int c = 0; c < 4; c++) begin
            if (col_we[c]) data_q[127-32*c -: 32] <= col_mixed;
         end
         col_q <= col_q + 2'd1;
      end else if (unload) begin
         data_q <= '0;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign data_o      = out_valid_o ? data_q : 128'h0;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed bench for aes_mix_columns_iter with a queue of expected results
// and an independent matrix-based GF(2^8) reference model.
module tb_aes_mix_columns_iter;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         clear_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic         mode_i;
   logic [127:0] data_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [127:0] data_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   aes_mix_columns_iter dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .mode_i      (mode_i),
      .data_i      (data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .data_o      (data_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] ref_col(input logic [31:0] col, input logic dec);
      logic [7:0] a [4];
      logic [7:0] coef [4];
      logic [31:0] r = 32'h0;
      for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
      if (dec) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
      else     begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
      for (int row = 0; row < 4; row++) begin
         logic [7:0] acc = 8'h00;
         for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - row + 4) % 4]);
         r[31-8*row -: 8] = acc;
      end
      return r;
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] s, input logic dec);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = ref_col(s[127-32*c -: 32], dec);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  128'(in_ready_o),  128'd1);
      chk({tag, "_out_valid"}, 128'(out_valid_o), 128'd0);
      chk({tag, "_busy"},      128'(busy_o),      128'd0);
      chk({tag, "_data_o"},    data_o,            128'd0);
   endtask

   // Offers a block at a negedge; the handshake happens at the following posedge.
   task automatic send(input logic m, input logic [127:0] d);
      @(negedge clk_i);
      chk("in_ready_before_send", 128'(in_ready_o), 128'd1);
      in_valid_i = 1'b1;
      mode_i     = m;
      data_i     = d;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      mode_i     = ~m;
      data_i     = '1;
   endtask

   task automatic wait_out(input string tag, output int lat);
      lat = 0;
      while (!out_valid_o && lat < 20) begin
         chk({tag, "_zero_while_invalid"}, data_o, 128'd0);
         @(negedge clk_i);
         lat++;
      end
      if (!out_valid_o) chk({tag, "_timeout"}, 128'(out_valid_o), 128'd1);
   endtask

   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 128'(exp_q.size()), 128'd1);
      end else begin
         chk(tag, data_o, exp_q.pop_front());
      end
   endtask

   initial begin
      int lat;
      logic [127:0] blk, snap;

      rst_ni      = 1'b0;
      clear_i     = 1'b0;
      in_valid_i  = 1'b0;
      mode_i      = 1'b0;
      data_i      = '0;
      out_ready_i = 1'b1;
      #12;
      chk_reset_outputs("reset");
      rst_ni = 1'b1;

      // MixColumns known answer with latency check
      exp_q.push_back(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      send(1'b0, 128'hdb135345_f20a225c_01010101_2d26314c);
      wait_out("enc_kat", lat);
      chk("enc_kat_latency", 128'(lat), 128'd4);
      pop_check("enc_kat_data");
      @(negedge clk_i);
      chk("enc_kat_valid_after_hs", 128'(out_valid_o), 128'd0);
      chk("enc_kat_ready_after_hs", 128'(in_ready_o), 128'd1);

      // InvMixColumns round trip
      exp_q.push_back(128'hdb135345_f20a225c_01010101_2d26314c);
      send(1'b1, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      wait_out("dec_kat", lat);
      chk("dec_kat_latency", 128'(lat), 128'd4);
      pop_check("dec_kat_data");
      @(negedge clk_i);
      chk("dec_kat_zero_after_hs", data_o, 128'd0);

      // Backpressure: hold result for 10 cycles
      out_ready_i = 1'b0;
      blk = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_state(blk, 1'b0));
      send(1'b0, blk);
      wait_out("bp", lat);
      pop_check("bp_data");
      snap = ref_state(blk, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         chk("bp_valid_hold", 128'(out_valid_o), 128'd1);
         chk("bp_data_hold", data_o, snap);
         chk("bp_in_ready_low", 128'(in_ready_o), 128'd0);
      end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      chk("bp_valid_drop", 128'(out_valid_o), 128'd0);
      chk("bp_in_ready_back", 128'(in_ready_o), 128'd1);

      // Mode toggling during BUSY must not disturb an ENC block
      blk = 128'hc6c6c6c6_d4d4d4d5_d4d4d4d5_c6c6c6c6;
      exp_q.push_back(ref_state(blk, 1'b0));
      send(1'b0, blk);
      for (int i = 0; i < 3; i++) begin
         mode_i = ~mode_i;
         @(negedge clk_i);
      end
      mode_i = ~mode_i;
      wait_out("mode_tog", lat);
      chk("mode_tog_col1", 128'(data_o[95:64]), 128'h0000_0000_0000_0000_0000_0000_d5d5_d7d6);
      chk("mode_tog_col0", 128'(data_o[127:96]), 128'h0000_0000_0000_0000_0000_0000_c6c6_c6c6);
      pop_check("mode_tog_data");
      @(negedge clk_i);

      // clear_i in the 2nd BUSY cycle with a competing input
      send(1'b0, {$urandom, $urandom, $urandom, $urandom});
      @(negedge clk_i);
      clear_i    = 1'b1;
      in_valid_i = 1'b1;
      data_i     = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk_i);
      clear_i    = 1'b0;
      in_valid_i = 1'b0;
      chk("clr_busy", 128'(busy_o), 128'd0);
      chk("clr_in_ready", 128'(in_ready_o), 128'd1);
      chk("clr_out_valid", 128'(out_valid_o), 128'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         chk("clr_no_valid", 128'(out_valid_o), 128'd0);
         chk("clr_stays_idle", 128'(busy_o), 128'd0);
      end
      blk = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_state(blk, 1'b1));
      send(1'b1, blk);
      wait_out("post_clr", lat);
      chk("post_clr_latency", 128'(lat), 128'd4);
      pop_check("post_clr_data");
      @(negedge clk_i);

      // Async reset mid-BUSY
      send(1'b0, {$urandom, $urandom, $urandom, $urandom});
      @(negedge clk_i);
      chk("rst_busy_pre", 128'(busy_o), 128'd1);
      rst_ni = 1'b0;
      #1;
      chk_reset_outputs("rst_mid_busy");
      #1;
      rst_ni = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         chk("rst_busy_no_valid", 128'(out_valid_o), 128'd0);
      end

      // Async reset mid-DONE
      out_ready_i = 1'b0;
      blk = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_state(blk, 1'b0));
      send(1'b0, blk);
      wait_out("rst_done", lat);
      pop_check("rst_done_data");
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk_reset_outputs("rst_mid_done");
      #1;
      rst_ni = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      chk_reset_outputs("rst_done_after");

      // Random blocks in both directions, back to back
      for (int k = 0; k < 6; k++) begin
         logic m;
         m   = 1'($urandom_range(0, 1));
         blk = {$urandom, $urandom, $urandom, $urandom};
         exp_q.push_back(ref_state(blk, m));
         send(m, blk);
         wait_out("rand", lat);
         chk("rand_latency", 128'(lat), 128'd4);
         pop_check("rand_data");
      end
      @(negedge clk_i);
      chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
